// File: rtl/life_grid_engine_if.sv
`default_nettype none
// ============================================================================
// life_grid_engine_if
// ----------------------------------------------------------------------------
// Control, load, display-read and status bundle of the Game of Life engine.
//   master : control side (buttons/switches, tick source, VGA mapper)
//   slave  : life_grid_engine
// Signals:
//   run, tick, step     generation start controls
//   load_en, load_row,
//   load_data           row write port (bit j = column j)
//   rd_row / rd_data    display read port (1-cycle latency)
//   busy, done          generation status
//   gen_count,
//   pop_count           completed generations / live cells
// Revision: 1.0 - initial release
// ============================================================================
interface life_grid_engine_if #(
  parameter int ROWS  = 48,
  parameter int COLS  = 64,
  parameter int GEN_W = 16
);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(ROWS*COLS+1);

  logic             run;
  logic             tick;
  logic             step;
  logic             load_en;
  logic [RW-1:0]    load_row;
  logic [COLS-1:0]  load_data;
  logic [RW-1:0]    rd_row;
  logic [COLS-1:0]  rd_data;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gen_count;
  logic [PW-1:0]    pop_count;

  modport master (
    output run, tick, step, load_en, load_row, load_data, rd_row,
    input  rd_data, busy, done, gen_count, pop_count
  );

  modport slave (
    input  run, tick, step, load_en, load_row, load_data, rd_row,
    output rd_data, busy, done, gen_count, pop_count
  );
endinterface
`default_nettype wire

// File: rtl/life_grid_engine.sv
`default_nettype none
// ============================================================================
// life_grid_engine
// ----------------------------------------------------------------------------
// Conway's Game of Life (B3/S23) engine. Holds a ROWS x COLS grid and
// computes one generation per start, one row per board_clk cycle, updating
// the array in place. Optional toroidal wrap (WRAP=1).
// Ports:
//   board_clk  system clock
//   reset      asynchronous, active-high
//   bus        life_grid_engine_if slave: run/tick/step starts, row load,
//              registered display read, busy/done, gen_count, pop_count
// Revision: 1.0 - initial release
// ============================================================================
module life_grid_engine #(
  parameter int ROWS  = 48,
  parameter int COLS  = 64,
  parameter int WRAP  = 0,
  parameter int GEN_W = 16
) (
  input  wire logic          board_clk,
  input  wire logic          reset,
  life_grid_engine_if.slave  bus
);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(ROWS*COLS+1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_UPDATE = 1'b1;

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);

  logic [COLS-1:0]  grid_q [ROWS];
  logic [0:0]       state_q, state_d;
  logic [RW-1:0]    k_q, k_d;
  logic [COLS-1:0]  prev_q, prev_d;    // old contents of row k-1
  logic [COLS-1:0]  first_q, first_d;  // old contents of row 0 (wrap source)
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    pop_q, pop_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             done_q, done_d;
  logic [COLS-1:0]  rd_q, rd_d;

  logic             last_row;
  logic [RW-1:0]    k_below;
  logic [COLS-1:0]  row_above, row_cur, row_below, row_new;
  logic [COLS+1:0]  ext_a, ext_c, ext_b;
  logic [3:0]       nbr;
  logic [PW-1:0]    row_pop;
  logic             start, load_ok, wr_load, wr_row;

  // Pad a row by one column on each side: wrapped columns or dead cells.
  function automatic logic [COLS+1:0] pad_row(input logic [COLS-1:0] r);
    logic lo, hi;
    lo = (WRAP != 0) ? r[COLS-1] : 1'b0;
    hi = (WRAP != 0) ? r[0] : 1'b0;
    return {hi, r, lo};
  endfunction

  // Neighbourhood rows. Row k-1 has already been overwritten, so its old
  // value comes from prev_q; row 0 is likewise gone by the time the last
  // row needs it as a wrapped neighbour, hence first_q.
  always_comb begin
    last_row = (k_q == LAST_ROW);
    k_below  = last_row ? '0 : k_q + 1'b1;
    row_cur  = grid_q[k_q];
    if (k_q == '0) row_above = (WRAP != 0) ? grid_q[ROWS-1] : '0;
    else           row_above = prev_q;
    if (last_row)  row_below = (WRAP != 0) ? first_q : '0;
    else           row_below = grid_q[k_below];
  end

  always_comb begin
    ext_a   = pad_row(row_above);
    ext_c   = pad_row(row_cur);
    ext_b   = pad_row(row_below);
    row_new = '0;
    row_pop = '0;
    nbr     = '0;
    for (int j = 0; j < COLS; j++) begin
      nbr = 4'(ext_a[j]) + 4'(ext_a[j+1]) + 4'(ext_a[j+2]) +
            4'(ext_c[j])                  + 4'(ext_c[j+2]) +
            4'(ext_b[j]) + 4'(ext_b[j+1]) + 4'(ext_b[j+2]);
      row_new[j] = (nbr == 4'd3) || (ext_c[j+1] && (nbr == 4'd2));
      row_pop    = row_pop + PW'(row_new[j]);
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    prev_d  = prev_q;
    first_d = first_q;
    acc_d   = acc_q;
    pop_d   = pop_q;
    gen_d   = gen_q;
    done_d  = 1'b0;
    wr_load = 1'b0;
    wr_row  = 1'b0;
    start   = bus.step | (bus.run & bus.tick);
    load_ok = ({1'b0, bus.load_row} < (RW+1)'(ROWS));
    case (state_q)
      S_IDLE: begin
        // A load wins and swallows any start presented in the same cycle.
        if (bus.load_en) begin
          wr_load = load_ok;
        end else if (start) begin
          state_d = S_UPDATE;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      S_UPDATE: begin
        wr_row = 1'b1;
        prev_d = row_cur;
        if (k_q == '0) first_d = row_cur;
        acc_d = acc_q + row_pop;
        k_d   = k_q + 1'b1;
        if (last_row) begin
          state_d = S_IDLE;
          k_d     = '0;
          pop_d   = acc_q + row_pop;
          gen_d   = gen_q + 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rd_d = ({1'b0, bus.rd_row} < (RW+1)'(ROWS)) ? grid_q[bus.rd_row] : '0;
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      prev_q  <= '0;
      first_q <= '0;
      acc_q   <= '0;
      pop_q   <= '0;
      gen_q   <= '0;
      done_q  <= 1'b0;
      rd_q    <= '0;
      for (int r = 0; r < ROWS; r++) grid_q[r] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      prev_q  <= prev_d;
      first_q <= first_d;
      acc_q   <= acc_d;
      pop_q   <= pop_d;
      gen_q   <= gen_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      if (wr_load) grid_q[bus.load_row] <= bus.load_data;
      if (wr_row)  grid_q[k_q] <= row_new;
    end
  end

  assign bus.busy      = (state_q == S_UPDATE);
  assign bus.done      = done_q;
  assign bus.gen_count = gen_q;
  assign bus.pop_count = pop_q;
  assign bus.rd_data   = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_life_grid_engine.sv
`default_nettype none
// ============================================================================
// tb_life_grid_engine
// ----------------------------------------------------------------------------
// Self-checking bench for life_grid_engine. Three instances:
//   dut0 48x64 WRAP=0 GEN_W=16, dut1 8x8 WRAP=1 GEN_W=16,
//   dut2 4x4 WRAP=0 GEN_W=4.
// Expected pop_count/gen_count per generation are queued when a start is
// driven and compared when done pulses.
// Revision: 1.0 - initial release
// ============================================================================
module tb_life_grid_engine;
  logic board_clk = 1'b0;
  logic reset     = 1'b1;
  always #5 board_clk = ~board_clk;

  life_grid_engine_if #(.ROWS(48), .COLS(64), .GEN_W(16)) bus0 ();
  life_grid_engine_if #(.ROWS(8),  .COLS(8),  .GEN_W(16)) bus1 ();
  life_grid_engine_if #(.ROWS(4),  .COLS(4),  .GEN_W(4))  bus2 ();

  life_grid_engine #(.ROWS(48), .COLS(64), .WRAP(0), .GEN_W(16)) u_dut0 (
    .board_clk(board_clk), .reset(reset), .bus(bus0));
  life_grid_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(16)) u_dut1 (
    .board_clk(board_clk), .reset(reset), .bus(bus1));
  life_grid_engine #(.ROWS(4), .COLS(4), .WRAP(0), .GEN_W(4)) u_dut2 (
    .board_clk(board_clk), .reset(reset), .bus(bus2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct { logic [15:0] pop; logic [15:0] gen; } exp_t;
  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  int d0 = 0, d1 = 0, d2 = 0;

  always @(negedge board_clk) begin
    if (bus0.done) begin
      d0++;
      if (q0.size() == 0) check("dut0 unexpected done", 64'(bus0.done), 64'd0);
      else begin
        e0 = q0.pop_front();
        check("dut0 pop_count", 64'(bus0.pop_count), 64'(e0.pop));
        check("dut0 gen_count", 64'(bus0.gen_count), 64'(e0.gen));
      end
    end
    if (bus1.done) begin
      d1++;
      if (q1.size() == 0) check("dut1 unexpected done", 64'(bus1.done), 64'd0);
      else begin
        e1 = q1.pop_front();
        check("dut1 pop_count", 64'(bus1.pop_count), 64'(e1.pop));
        check("dut1 gen_count", 64'(bus1.gen_count), 64'(e1.gen));
      end
    end
    if (bus2.done) begin
      d2++;
      if (q2.size() == 0) check("dut2 unexpected done", 64'(bus2.done), 64'd0);
      else begin
        e2 = q2.pop_front();
        check("dut2 pop_count", 64'(bus2.pop_count), 64'(e2.pop));
        check("dut2 gen_count", 64'(bus2.gen_count), 64'(e2.gen));
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic busy_of(input int w);
    case (w)
      0:       return bus0.busy;
      1:       return bus1.busy;
      default: return bus2.busy;
    endcase
  endfunction

  task automatic clear_inputs();
    bus0.run = 0; bus0.tick = 0; bus0.step = 0; bus0.load_en = 0;
    bus0.load_row = '0; bus0.load_data = '0; bus0.rd_row = '0;
    bus1.run = 0; bus1.tick = 0; bus1.step = 0; bus1.load_en = 0;
    bus1.load_row = '0; bus1.load_data = '0; bus1.rd_row = '0;
    bus2.run = 0; bus2.tick = 0; bus2.step = 0; bus2.load_en = 0;
    bus2.load_row = '0; bus2.load_data = '0; bus2.rd_row = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge board_clk);
    #1 reset = 1'b0;
  endtask

  task automatic load(input int w, input int r, input logic [63:0] d);
    case (w)
      0: begin bus0.load_en = 1; bus0.load_row = 6'(r); bus0.load_data = d; end
      1: begin bus1.load_en = 1; bus1.load_row = 3'(r); bus1.load_data = d[7:0]; end
      default: begin bus2.load_en = 1; bus2.load_row = 2'(r); bus2.load_data = d[3:0]; end
    endcase
    @(posedge board_clk); #1;
    bus0.load_en = 0; bus1.load_en = 0; bus2.load_en = 0;
  endtask

  task automatic read(input int w, input int r, output logic [63:0] d);
    case (w)
      0:       bus0.rd_row = 6'(r);
      1:       bus1.rd_row = 3'(r);
      default: bus2.rd_row = 2'(r);
    endcase
    @(posedge board_clk); #1;
    case (w)
      0:       d = 64'(bus0.rd_data);
      1:       d = 64'(bus1.rd_data);
      default: d = 64'(bus2.rd_data);
    endcase
  endtask

  task automatic pulse_step(input int w);
    case (w)
      0:       bus0.step = 1;
      1:       bus1.step = 1;
      default: bus2.step = 1;
    endcase
    @(posedge board_clk); #1;
    bus0.step = 0; bus1.step = 0; bus2.step = 0;
  endtask

  // Called right after the start edge; counts busy cycles with a bound.
  task automatic wait_idle(input int w, input int exp_cyc, input string nm);
    int cnt;
    cnt = 0;
    while (busy_of(w) && cnt < 1000) begin
      @(posedge board_clk); #1;
      cnt++;
    end
    check(nm, 64'(cnt), 64'(exp_cyc));
  endtask

  // ---------------- vector table (dut0) ----------------
  typedef struct {
    int          b;
    logic [63:0] pat [5];
    logic [63:0] exp [5];
    int          pop;
  } vec_t;
  vec_t tv [5];

  logic [63:0] d;
  int          c;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{9,  '{0, 64'h7 << 20, 0, 0, 0},
                  '{64'h1 << 21, 64'h1 << 21, 64'h1 << 21, 0, 0}, 3};
    tv[1] = '{0,  '{64'h7, 0, 0, 0, 0}, '{64'h2, 64'h2, 0, 0, 0}, 2};
    tv[2] = '{19, '{0, 64'h60, 64'h60, 0, 0}, '{0, 64'h60, 64'h60, 0, 0}, 4};
    tv[3] = '{43, '{0, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'h8000_0000_0000_0000},
                  '{0, 0, 0, 64'hC000_0000_0000_0000, 0}, 2};
    tv[4] = '{30, '{0, 64'h1 << 40, 64'h1 << 40, 64'h1 << 40, 0},
                  '{0, 0, 64'h7 << 39, 0, 0}, 3};

    // Reset state
    do_reset();
    check("reset busy", 64'(bus0.busy), 64'd0);
    check("reset done", 64'(bus0.done), 64'd0);
    check("reset gen_count", 64'(bus0.gen_count), 64'd0);
    check("reset pop_count", 64'(bus0.pop_count), 64'd0);
    read(0, 10, d);
    check("reset rd_data", d, 64'd0);

    // Single-step patterns on the 48x64 clipped grid
    for (int t = 0; t < 5; t++) begin
      do_reset();
      for (int i = 0; i < 5; i++) load(0, tv[t].b + i, tv[t].pat[i]);
      q0.push_back('{16'(tv[t].pop), 16'd1});
      pulse_step(0);
      wait_idle(0, 48, "vec busy cycles");
      @(posedge board_clk); #1;
      for (int i = 0; i < 5; i++) begin
        read(0, tv[t].b + i, d);
        check($sformatf("vec%0d row%0d", t, tv[t].b + i), d, tv[t].exp[i]);
      end
    end

    // Blinker second step restores original, 1-cycle gap between starts
    do_reset();
    load(0, 10, 64'h7 << 20);
    q0.push_back('{16'd3, 16'd1});
    pulse_step(0);
    wait_idle(0, 48, "blinker gen1 busy");
    q0.push_back('{16'd3, 16'd2});
    pulse_step(0);
    wait_idle(0, 48, "blinker gen2 busy");
    @(posedge board_clk); #1;
    read(0, 9, d);  check("blinker2 row9", d, 64'd0);
    read(0, 10, d); check("blinker2 row10", d, 64'h7 << 20);
    read(0, 11, d); check("blinker2 row11", d, 64'd0);

    // Load/step ignored while busy; block is a still life
    do_reset();
    load(0, 20, 64'h60);
    load(0, 21, 64'h60);
    q0.push_back('{16'd4, 16'd1});
    pulse_step(0);
    repeat (5) @(posedge board_clk); #1;
    bus0.load_en = 1; bus0.load_row = 6'd30; bus0.load_data = '1; bus0.step = 1;
    @(posedge board_clk); #1;
    bus0.load_en = 0; bus0.step = 0;
    wait_idle(0, 42, "busy-ignore remaining busy");
    repeat (3) @(posedge board_clk); #1;
    check("no start after busy", 64'(bus0.busy), 64'd0);
    read(0, 30, d); check("load during busy dropped", d, 64'd0);
    read(0, 20, d); check("block row20", d, 64'h60);
    read(0, 21, d); check("block row21", d, 64'h60);

    // load_en and step together in IDLE: load only
    bus0.load_en = 1; bus0.load_row = 6'd5; bus0.load_data = 64'hDEAD; bus0.step = 1;
    @(posedge board_clk); #1;
    bus0.load_en = 0; bus0.step = 0;
    check("load+step no busy", 64'(bus0.busy), 64'd0);
    repeat (3) @(posedge board_clk); #1;
    read(0, 5, d); check("load+step row5", d, 64'hDEAD);
    check("load+step gen_count", 64'(bus0.gen_count), 64'd1);

    // Glider on the 8x8 torus: 32 generations return it home
    do_reset();
    load(1, 0, 64'h02);
    load(1, 1, 64'h04);
    load(1, 2, 64'h07);
    for (int i = 0; i < 3; i++) begin
      bus1.tick = 1; @(posedge board_clk); #1; bus1.tick = 0;
      check("tick with run=0", 64'(bus1.busy), 64'd0);
    end
    bus1.run = 1;
    for (int g = 0; g < 32; g++) begin
      q1.push_back('{16'd5, 16'(g + 1)});
      bus1.tick = 1; @(posedge board_clk); #1; bus1.tick = 0;
      repeat (19) @(posedge board_clk);
    end
    #1 bus1.run = 0;
    check("glider gen_count", 64'(bus1.gen_count), 64'd32);
    for (int r = 0; r < 8; r++) begin
      read(1, r, d);
      check($sformatf("glider row%0d", r), d,
            (r == 0) ? 64'h02 : (r == 1) ? 64'h04 : (r == 2) ? 64'h07 : 64'h0);
    end

    // Block with run=1 and tick every cycle on the 4x4 grid
    do_reset();
    load(2, 1, 64'h6);
    load(2, 2, 64'h6);
    for (int g = 0; g < 4; g++) q2.push_back('{16'd4, 16'(g + 1)});
    c = d2;
    bus2.run = 1; bus2.tick = 1;
    repeat (20) @(posedge board_clk);
    #1 bus2.tick = 0; bus2.run = 0;
    repeat (3) @(posedge board_clk); #1;
    check("tick-every-cycle done count", 64'(d2 - c), 64'd4);
    for (int r = 0; r < 4; r++) begin
      read(2, r, d);
      check($sformatf("still row%0d", r), d, (r == 1 || r == 2) ? 64'h6 : 64'h0);
    end

    // GEN_W=4 counter wraps after 16 generations
    do_reset();
    load(2, 1, 64'h6);
    load(2, 2, 64'h6);
    c = d2;
    for (int g = 0; g < 16; g++) begin
      q2.push_back('{16'd4, 16'((g + 1) % 16)});
      pulse_step(2);
      wait_idle(2, 4, "dut2 busy cycles");
    end
    @(posedge board_clk); #1;
    check("wrap done pulses", 64'(d2 - c), 64'd16);
    check("wrap gen_count", 64'(bus2.gen_count), 64'd0);

    // Reset aborts a generation in flight
    do_reset();
    load(0, 10, 64'h7 << 20);
    q0.push_back('{16'd3, 16'd1});
    pulse_step(0);
    wait_idle(0, 48, "pre-abort busy");
    @(posedge board_clk); #1;
    pulse_step(0);
    repeat (19) @(posedge board_clk);
    #1 reset = 1'b1;
    c = d0;
    #1;
    check("abort busy", 64'(bus0.busy), 64'd0);
    check("abort done", 64'(bus0.done), 64'd0);
    repeat (2) @(posedge board_clk);
    #1 reset = 1'b0;
    repeat (60) @(posedge board_clk); #1;
    check("abort no done pulse", 64'(d0 - c), 64'd0);
    check("abort gen_count", 64'(bus0.gen_count), 64'd0);
    check("abort pop_count", 64'(bus0.pop_count), 64'd0);
    for (int r = 0; r < 48; r++) begin
      read(0, r, d);
      check($sformatf("abort row%0d", r), d, 64'd0);
    end

    check("dut0 pending expectations", 64'(q0.size()), 64'd0);
    check("dut1 pending expectations", 64'(q1.size()), 64'd0);
    check("dut2 pending expectations", 64'(q2.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/life_grid_engine.md
# life_grid_engine

Parametrised Conway's Game of Life (B3/S23) engine for the VGA life display. It holds a ROWS x COLS cell grid and computes one generation per start event, row-serially at one row per board_clk cycle. Optional toroidal wrap, single-step and run modes, a row load port, a registered display read port, a generation counter and a population count. Sits between the button/switch control logic and the VGA pixel mapper; the slow display tick drives run mode.

## Interface

- ROWS, 48, grid rows (>= 3)
- COLS, 64, grid columns (>= 3)
- WRAP, 0, 1 = toroidal edges; 0 = cells outside the grid are dead
- GEN_W, 16, generation counter width
- board_clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock board_clk
- run  in  1  level; when 1, each tick pulse starts one generation
- tick  in  1  single-cycle pulse, generation rate in run mode
- step  in  1  single-cycle pulse; starts one generation regardless of run
- load_en  in  1  write load_data into grid row load_row
- load_row  in  clog2(ROWS)  row index for load
- load_data  in  COLS  row contents; bit j = column j
- rd_row  in  clog2(ROWS)  display read row index
- rd_data  out  COLS  registered contents of row rd_row
- busy  out  1  generation in progress
- done  out  1  one-cycle pulse when a generation completes
- gen_count  out  GEN_W  completed generations since reset
- pop_count  out  clog2(ROWS*COLS+1)  live cells in the latest generation

## Operation

- Two states: IDLE, UPDATE. Reset clears the grid to all zero and sets state IDLE. Outputs after reset: busy=0, done=0, gen_count=0, pop_count=0, rd_data=0.
- IDLE priority, highest first: load_en, then step, then (run & tick). With load_en=1, the load executes and any start in the same cycle is dropped. Otherwise step=1 or (run=1 and tick=1) moves the engine to UPDATE with row index k=0 and clears the population accumulator.
- UPDATE: each cycle writes the new value of row k in place, then k increments. After row ROWS-1 the engine returns to IDLE.
- Neighbourhood for row k uses old rows k-1, k and k+1:
  - Old row k-1 comes from a saved-row register, because that row has already been overwritten.
  - Old row k+1 is still unmodified in the array.
  - With WRAP=1, row k=0 uses old row ROWS-1 from the array. Row ROWS-1 uses a copy of old row 0 captured on the first UPDATE cycle. Column neighbours wrap modulo COLS.
  - With WRAP=0, out-of-grid neighbours are 0.
- Cell rule: next = (n==3) | (cell & n==2), where n is the live-neighbour count, 0..8.
- Population: per-row popcount of the new row is added to the accumulator each UPDATE cycle. The total is loaded into pop_count when the generation completes.
- gen_count increments by 1 per completed generation and wraps modulo 2^GEN_W.
- During UPDATE, load_en, step and tick are ignored, not queued.
- run=0 with tick pulses: no generation starts.
- rd_data is valid in every state. During UPDATE, rows < k show the new generation and rows >= k show the old one. The display samples only when busy=0.

## Timing

- A start accepted on clock edge E sets busy=1 from E to E+ROWS.
- New row k is written at edge E+1+k.
- On edge E+ROWS: busy becomes 0, done pulses high for one cycle, gen_count increments and pop_count updates, all on the same edge.
- Generation latency is ROWS cycles; back-to-back starts are possible with a 1-cycle IDLE gap.
- A load is visible in the array on the edge after load_en. rd_data has a 1-cycle latency from rd_row.
- Reset asserted mid-UPDATE aborts immediately: grid zeroed, counters zeroed, busy=0, no done pulse.

## Test plan

- Blinker, WRAP=0, default size: load row 10 with bits 20..22, then step. Required: busy high 48 cycles; done one cycle; rows 9/10/11 each have only bit 21 set; pop_count=3; gen_count=1. Second step restores the original pattern.
- Edge clipping, WRAP=0: row 0 bits 0..2, then step. Required: cells (0,1) and (1,1) only; pop_count=2.
- Glider wrap, WRAP=1, ROWS=COLS=8: run=1, 32 tick pulses spaced 20 cycles apart. Required: grid equals the initial glider; gen_count=32; pop_count=5 after each generation.
- Still life and priority: 2x2 block with run=1 and tick every cycle. Required: grid is unchanged and pop_count=4. load_en pulsed during busy leaves the grid unchanged. load_en and step together in IDLE perform the load with no generation.
- Counter wrap, GEN_W=4: 16 steps. Required: gen_count=0 and exactly 16 done pulses.
- Reset at cycle 20 of an UPDATE. Required: busy=0, done never pulses, rd_data=0 for every row, gen_count=0, pop_count=0.
